// File: rtl/serial_key_lfsr_pkg.sv
// Shared command codes, sequencer state encoding and bus window decode
// for the serial key generator.
package serial_key_pkg;

  typedef enum logic [3:0] {
    ADV    = 4'h0,
    PEEK   = 4'h1,
    LOAD   = 4'h2,
    RESEED = 4'h3,
    UNLK_B = 4'h5,
    UNLK_A = 4'hA,
    LOCK   = 4'hF
  } cmd_e;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    ARM1   = 2'd1,
    ARM2   = 2'd2,
    RUN    = 2'd3
  } fsm_e;

  localparam logic [1:0] WIN_SERIAL = 2'b01;

endpackage

// File: rtl/serial_key_lfsr_if.sv
// Serial-window bus seen by the key generator: host access qualifiers
// and the tristate-able key data bit.
interface serial_key_lfsr_if;
  logic        bus_sel_n;
  logic [13:0] bus_addr;
  logic        bus_rw;
  logic        bus_strobe;
  logic        sdrd;
  logic        sdrd_oe;

  modport master (
    output bus_sel_n, bus_addr, bus_rw, bus_strobe,
    input  sdrd, sdrd_oe
  );

  modport slave (
    input  bus_sel_n, bus_addr, bus_rw, bus_strobe,
    output sdrd, sdrd_oe
  );
endinterface

// File: rtl/serial_key_lfsr_core.sv
// Fibonacci LFSR register with shift, nibble load, reseed and
// zero-lockup recovery; only the low WIDTH bits of TAPS/SEED matter.
module lfsr_core
  import serial_key_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter logic [31:0] TAPS  = 32'h0000_B400,
  parameter logic [31:0] SEED  = 32'h0000_ACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             load,
  input  logic             reseed,
  input  logic [3:0]       nib,
  output logic [WIDTH-1:0] state,
  output logic             fb
);

  localparam logic [WIDTH-1:0] TAP_M  = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_V = SEED[WIDTH-1:0];

  logic [WIDTH-1:0] state_nx;

  assign fb = ^(state & TAP_M);

  always_comb begin
    state_nx = state;
    if (reseed) begin
      state_nx = SEED_V;
    end else if (load) begin
      state_nx = {state[WIDTH-5:0], nib};
    end else if (adv) begin
      // an all-zero register would never leave zero, so an advance reseeds it
      state_nx = (state == '0) ? SEED_V : {state[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SEED_V;
    else     state <= state_nx;
  end

endmodule

// File: rtl/serial_key_lfsr.sv
// Serial key generator top: window/command decode and the unlock
// sequencer in front of the LFSR core.
//
// state  | meaning
// LOCKED | waiting for UNLK_A write with arg KEY0
// ARM1   | first nibble seen, expecting UNLK_B with KEY1
// ARM2   | second nibble seen, expecting UNLK_B with KEY0^KEY1
// RUN    | key commands accepted, unlocked high
module serial_key_lfsr
  import serial_key_pkg::*;
#(
  parameter int          WIDTH = 16,
  parameter logic [31:0] TAPS  = 32'h0000_B400,
  parameter logic [31:0] SEED  = 32'h0000_ACE1,
  parameter logic [3:0]  KEY0  = 4'h9,
  parameter logic [3:0]  KEY1  = 4'h6
) (
  input  logic             clk,
  input  logic             rst,
  serial_key_lfsr_if.slave bus,
  output logic [WIDTH-1:0] state_q,
  output logic             unlocked
);

  localparam logic [1:0] ST_LOCKED = LOCKED;
  localparam logic [1:0] ST_ARM1   = ARM1;
  localparam logic [1:0] ST_ARM2   = ARM2;
  localparam logic [1:0] ST_RUN    = RUN;

  logic [1:0] fsm, fsm_nx;
  logic       acc, rd_acc, wr_acc, run;
  logic [3:0] cmd, arg;
  logic       adv, peek, load, reseed, fb;
  logic       unused_addr;

  assign acc    = bus.bus_strobe & ~bus.bus_sel_n & (bus.bus_addr[13:12] == WIN_SERIAL);
  assign rd_acc = acc & bus.bus_rw;
  assign wr_acc = acc & ~bus.bus_rw;
  assign cmd    = bus.bus_addr[7:4];
  assign arg    = bus.bus_addr[3:0];
  assign unused_addr = ^bus.bus_addr[11:8];

  assign run    = (fsm == ST_RUN);
  assign adv    = run & rd_acc & (cmd == ADV);
  assign peek   = run & rd_acc & (cmd == PEEK);
  assign load   = run & wr_acc & (cmd == LOAD);
  assign reseed = run & wr_acc & (cmd == RESEED);

  assign bus.sdrd_oe = rd_acc;
  assign bus.sdrd    = (adv | peek) & fb;
  assign unlocked    = run;

  always_comb begin
    fsm_nx = fsm;
    unique case (fsm)
      ST_LOCKED: if (wr_acc && cmd == UNLK_A && arg == KEY0) fsm_nx = ST_ARM1;
      ST_ARM1:   if (acc) fsm_nx = (wr_acc && cmd == UNLK_B && arg == KEY1) ? ST_ARM2 : ST_LOCKED;
      ST_ARM2:   if (acc) fsm_nx = (wr_acc && cmd == UNLK_B && arg == (KEY0 ^ KEY1)) ? ST_RUN : ST_LOCKED;
      ST_RUN:    if (acc && cmd == LOCK) fsm_nx = ST_LOCKED;
      default:   fsm_nx = ST_LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) fsm <= ST_LOCKED;
    else     fsm <= fsm_nx;
  end

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv),
    .load   (load),
    .reseed (reseed),
    .nib    (arg),
    .state  (state_q),
    .fb     (fb)
  );

endmodule

// File: tb/tb_serial_key_lfsr.sv
// Table-driven bench for serial_key_lfsr: each record is one bus cycle with
// the expected combinational outputs and post-edge state/unlocked.
module tb_serial_key_lfsr;
  import serial_key_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] state_q;
  logic        unlocked;

  serial_key_lfsr_if bus ();

  serial_key_lfsr dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .state_q  (state_q),
    .unlocked (unlocked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sel_n;
    logic        strobe;
    logic        rw;
    logic [13:0] addr;
    logic        e_oe;
    logic        e_sdrd;
    logic [15:0] e_state;
    logic        e_unl;
  } vec_t;

  typedef struct {
    int          idx;
    logic [15:0] state;
    logic        unl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // normal access: rst=0, sel_n=0, strobe=1
  function automatic vec_t va(logic rw, logic [13:0] addr, logic oe, logic sd, logic [15:0] st, logic unl);
    vec_t v;
    v = '{rst: 1'b0, sel_n: 1'b0, strobe: 1'b1, rw: rw, addr: addr,
          e_oe: oe, e_sdrd: sd, e_state: st, e_unl: unl};
    return v;
  endfunction

  function automatic vec_t vx(logic r, logic sel_n, logic strobe, logic rw, logic [13:0] addr,
                              logic oe, logic [15:0] st, logic unl);
    vec_t v;
    v = '{rst: r, sel_n: sel_n, strobe: strobe, rw: rw, addr: addr,
          e_oe: oe, e_sdrd: 1'b0, e_state: st, e_unl: unl};
    return v;
  endfunction

  initial begin
    exp_t e;
    rst = 1'b1;
    bus.bus_sel_n  = 1'b1;
    bus.bus_addr   = '0;
    bus.bus_rw     = 1'b0;
    bus.bus_strobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", -1, state_q, 16'hACE1);
    chk("reset_unl", -1, {15'd0, unlocked}, 16'd0);
    chk("reset_oe", -1, {15'd0, bus.sdrd_oe}, 16'd0);

    // locked read, unlock, advance/peek/load/reseed
    vecs.push_back(va(1, 14'h1000, 1, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h10A9, 0, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h1056, 0, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h105F, 0, 0, 16'hACE1, 1));
    vecs.push_back(va(1, 14'h1000, 1, 1, 16'h59C3, 1));
    vecs.push_back(va(1, 14'h1010, 1, 1, 16'h59C3, 1));
    vecs.push_back(va(1, 14'h1000, 1, 1, 16'hB387, 1));
    vecs.push_back(va(0, 14'h1030, 0, 0, 16'hACE1, 1));
    vecs.push_back(va(1, 14'h1000, 1, 1, 16'h59C3, 1));
    vecs.push_back(va(0, 14'h1027, 0, 0, 16'h9C37, 1));
    vecs.push_back(va(0, 14'h1030, 0, 0, 16'hACE1, 1));
    // zero lockup
    vecs.push_back(va(0, 14'h1020, 0, 0, 16'hCE10, 1));
    vecs.push_back(va(0, 14'h1020, 0, 0, 16'hE100, 1));
    vecs.push_back(va(0, 14'h1020, 0, 0, 16'h1000, 1));
    vecs.push_back(va(0, 14'h1020, 0, 0, 16'h0000, 1));
    vecs.push_back(va(1, 14'h1000, 1, 0, 16'hACE1, 1));
    // decode misses and no-effect commands
    vecs.push_back(vx(0, 1, 1, 1, 14'h1000, 0, 16'hACE1, 1));
    vecs.push_back(vx(0, 0, 1, 1, 14'h2000, 0, 16'hACE1, 1));
    vecs.push_back(vx(0, 0, 0, 1, 14'h1000, 0, 16'hACE1, 1));
    vecs.push_back(va(0, 14'h1090, 0, 0, 16'hACE1, 1));
    vecs.push_back(va(1, 14'h1020, 1, 0, 16'hACE1, 1));
    vecs.push_back(va(0, 14'h1000, 0, 0, 16'hACE1, 1));
    vecs.push_back(va(1, 14'h1000, 1, 1, 16'h59C3, 1));
    // relock keeps state; locked reads do nothing
    vecs.push_back(va(0, 14'h10F0, 0, 0, 16'h59C3, 0));
    vecs.push_back(va(1, 14'h1000, 1, 0, 16'h59C3, 0));
    vecs.push_back(va(1, 14'h1010, 1, 0, 16'h59C3, 0));
    // wrong key nibble, then partial sequences
    vecs.push_back(va(0, 14'h10A9, 0, 0, 16'h59C3, 0));
    vecs.push_back(va(0, 14'h1057, 0, 0, 16'h59C3, 0));
    vecs.push_back(va(0, 14'h1056, 0, 0, 16'h59C3, 0));
    vecs.push_back(va(0, 14'h105F, 0, 0, 16'h59C3, 0));
    vecs.push_back(va(0, 14'h10A9, 0, 0, 16'h59C3, 0));
    vecs.push_back(va(1, 14'h1056, 1, 0, 16'h59C3, 0));
    vecs.push_back(va(0, 14'h1056, 0, 0, 16'h59C3, 0));
    vecs.push_back(va(0, 14'h105F, 0, 0, 16'h59C3, 0));
    // rst beats a simultaneous unlock write
    vecs.push_back(vx(1, 0, 1, 0, 14'h10A9, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h1056, 0, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h105F, 0, 0, 16'hACE1, 0));
    // idle cycle in ARM1 holds; rst in ARM2 relocks
    vecs.push_back(va(0, 14'h10A9, 0, 0, 16'hACE1, 0));
    vecs.push_back(vx(0, 0, 0, 0, 14'h1056, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h1056, 0, 0, 16'hACE1, 0));
    vecs.push_back(vx(1, 0, 1, 0, 14'h105F, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h105F, 0, 0, 16'hACE1, 0));
    // full unlock after idle, advance, rst in RUN
    vecs.push_back(va(0, 14'h10A9, 0, 0, 16'hACE1, 0));
    vecs.push_back(vx(0, 0, 0, 0, 14'h0000, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h1056, 0, 0, 16'hACE1, 0));
    vecs.push_back(va(0, 14'h105F, 0, 0, 16'hACE1, 1));
    vecs.push_back(va(1, 14'h1000, 1, 1, 16'h59C3, 1));
    vecs.push_back(vx(1, 0, 0, 0, 14'h0000, 0, 16'hACE1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      bus.bus_sel_n  = vecs[i].sel_n;
      bus.bus_strobe = vecs[i].strobe;
      bus.bus_rw     = vecs[i].rw;
      bus.bus_addr   = vecs[i].addr;
      sb.push_back('{idx: i, state: vecs[i].e_state, unl: vecs[i].e_unl});
      #1;
      chk("sdrd_oe", i, {15'd0, bus.sdrd_oe}, {15'd0, vecs[i].e_oe});
      chk("sdrd", i, {15'd0, bus.sdrd}, {15'd0, vecs[i].e_sdrd});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", i);
      end else begin
        e = sb.pop_front();
        chk("state_q", e.idx, state_q, e.state);
        chk("unlocked", e.idx, {15'd0, unlocked}, {15'd0, e.unl});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/serial_key_lfsr.md
Name: serial_key_lfsr

Overview:
Bus-mapped serial key generator: a parametrised Fibonacci LFSR of WIDTH bits behind an address-coded command decoder and an unlock sequencer. The host reads one key bit per access on sdrd. The block sits on the serial-select bus window (sel low, addr[13:12]=01) beside the other copy-protection and serial peripherals. Over the fixed 6-bit sequencer it adds configurable width, taps, seed and unlock key, nibble seed loading, peek, reseed, relock and zero-lockup recovery.

Parameters:
WIDTH, 16, LFSR width; legal range 5..32
TAPS, 16'hB400, feedback mask; bit i set means state[i] is XORed into feedback
SEED, 16'hACE1, reset/reseed value; must be nonzero
KEY0, 4'h9, first unlock nibble
KEY1, 4'h6, second unlock nibble

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
bus_sel_n  in  1  serial window select, active-low
bus_addr  in  14  address; [13:12] window decode, [7:4] cmd, [3:0] arg
bus_rw  in  1  1=read, 0=write
bus_strobe  in  1  one-cycle access qualifier
sdrd  out  1  key data bit, valid while sdrd_oe=1
sdrd_oe  out  1  drive enable for sdrd (pad tristate lives outside the block)
state_q  out  WIDTH  current LFSR state (debug)
unlocked  out  1  high in RUN

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Valid access (acc) requires bus_strobe=1, bus_sel_n=0 and bus_addr[13:12]=2'b01. Let cmd=bus_addr[7:4] and arg=bus_addr[3:0]. There is at most one access per cycle.
- fb = XOR reduction of (state & TAPS).
- Reset: state=SEED, FSM=LOCKED, unlocked=0, sdrd_oe=0, sdrd=0.
- FSM states: LOCKED, ARM1, ARM2, RUN.
  - LOCKED: on write acc with cmd=A and arg=KEY0, go to ARM1. All other accesses leave the FSM in LOCKED.
  - ARM1: on write acc with cmd=5 and arg=KEY1, go to ARM2. Any other acc goes to LOCKED.
  - ARM2: on write acc with cmd=5 and arg=KEY0^KEY1, go to RUN. Any other acc goes to LOCKED.
  - A cycle with no acc holds the current state in every FSM state.
- RUN commands:
  - cmd 0, read: sdrd=fb combinationally in the same cycle. On the next edge, state <= {state[WIDTH-2:0], fb}.
  - cmd 1, read (peek): sdrd=fb. State does not change.
  - cmd 2, write: state <= {state[WIDTH-5:0], arg}.
  - cmd 3, write: state <= SEED.
  - cmd F, any direction: FSM goes to LOCKED. State is kept.
  - Any other cmd/direction combination: no effect.
- sdrd_oe = acc & bus_rw, combinational, in every FSM state.
- sdrd = fb only for read accesses with cmd 0 or 1 in RUN. Otherwise sdrd=0, including all reads while LOCKED/ARMx. Reads in LOCKED/ARMx never change state.
- Zero lockup: if state==0 at a cmd-0 read, sdrd=0 and state <= SEED instead of shifting. A nibble load may produce 0. Only the next advance recovers.
- Latency: state_q and unlocked update one edge after the accepted access.
- rst mid-sequence (ARMx or RUN) returns to LOCKED with state=SEED. rst wins over a simultaneous acc.
- Widths: the state is exactly WIDTH bits. Only the low WIDTH bits of TAPS and SEED are used.

Decomposition:
- Shared package serial_key_pkg holds:
  - cmd_e enum: ADV=0, PEEK=1, LOAD=2, RESEED=3, UNLK_A=A, UNLK_B=5, LOCK=F.
  - fsm_e enum: LOCKED, ARM1, ARM2, RUN.
  - Window decode constant: 2'b01.
- One sub-module, lfsr_core, owns state, fb, and the shift/load/reseed/zero-recovery next-state mux. The top holds decode and the FSM.

Test Plan:
- Reset, then cmd-0 read at 0x1000 -> sdrd_oe=1, sdrd=0, state_q stays 0xACE1, unlocked=0.
- Writes 0x10A9, 0x1056, 0x105F -> unlocked=1 one cycle after the third write. Then cmd-0 read -> sdrd=1, state_q=0x59C3. Next cmd-0 read -> sdrd=1, state_q=0xB387.
- In RUN with state 0x59C3: peek 0x1010 returns sdrd=1 and state is unchanged. Write 0x1027 -> state_q=0x9C37. Write 0x1030 -> state_q=0xACE1.
- Wrong unlock: 0x10A9 then 0x1057 -> back to LOCKED. Then 0x1056 alone does not unlock.
- Zero recovery: load nibbles 0,0,0,0 -> state 0. cmd-0 read -> sdrd=0, state_q=0xACE1.
- Relock and reset: write 0x10F0 in RUN -> unlocked=0, state kept. rst asserted in ARM2 -> LOCKED, state_q=0xACE1. An access with bus_sel_n=1 or addr[13:12]=10 -> no sdrd_oe and no state change.
